// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU and its program loader.
package cpu_pkg;

   localparam int CPU_RAM_BYTES = 16;
   localparam int DATA_W        = 8;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_WAIT_DONE,
      ST_COMPLETE
   } loader_state_t;

endpackage

// File: rtl/program_loader_if.sv
// Host byte stream plus CPU programming pins as seen by the program loader.
interface program_loader_if;
   import cpu_pkg::*;

   logic [DATA_W-1:0] host_data;
   logic              host_valid;
   logic              host_ready;
   logic [DATA_W-1:0] cpu_ui_in;
   logic              cpu_programming;
   logic              cpu_ready;
   logic              cpu_done_load;

   modport slave (
      input  host_data, host_valid, cpu_ready, cpu_done_load,
      output host_ready, cpu_ui_in, cpu_programming
   );

   modport master (
      output host_data, host_valid, cpu_ready, cpu_done_load,
      input  host_ready, cpu_ui_in, cpu_programming
   );

endinterface

// File: rtl/program_loader_fifo.sv
// Small synchronous FIFO with a combinational head; pointers carry one extra wrap bit.
module byte_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             do_push;
   logic             do_pop;

   // A pop in the same cycle frees the slot, so a full FIFO can still take a push.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign head  = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/program_loader.sv
// Buffers a host program image and paces it into the CPU's programming port.
module program_loader
   import cpu_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int PROG_BYTES = CPU_RAM_BYTES
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   program_loader_if.slave               bus,
   output logic                          busy,
   output logic                          done,
   output logic                          err_underrun,
   output logic                          err_early,
   output logic [$clog2(PROG_BYTES):0]   bytes_sent
);

   localparam int             CW        = $clog2(PROG_BYTES) + 1;
   localparam logic [CW-1:0]  PROG_CNT  = CW'(PROG_BYTES);
   localparam logic [CW-1:0]  LAST_CNT  = CW'(PROG_BYTES - 1);

   loader_state_t     state, state_nxt;
   logic [CW-1:0]     in_cnt, in_cnt_nxt;
   logic [CW-1:0]     sent_nxt;
   logic              eu_nxt, ee_nxt;

   logic              fifo_flush, fifo_push, fifo_pop;
   logic              fifo_full, fifo_empty;
   logic [DATA_W-1:0] fifo_head;

   byte_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (fifo_flush),
      .push  (fifo_push),
      .din   (bus.host_data),
      .pop   (fifo_pop),
      .full  (fifo_full),
      .empty (fifo_empty),
      .head  (fifo_head)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_IDLE;
         in_cnt       <= '0;
         bytes_sent   <= '0;
         err_underrun <= 1'b0;
         err_early    <= 1'b0;
      end else begin
         state        <= state_nxt;
         in_cnt       <= in_cnt_nxt;
         bytes_sent   <= sent_nxt;
         err_underrun <= eu_nxt;
         err_early    <= ee_nxt;
      end
   end

   always_comb begin
      state_nxt           = state;
      in_cnt_nxt          = in_cnt;
      sent_nxt            = bytes_sent;
      eu_nxt              = err_underrun;
      ee_nxt              = err_early;
      fifo_flush          = 1'b0;
      fifo_push           = 1'b0;
      fifo_pop            = 1'b0;
      bus.host_ready      = 1'b0;
      bus.cpu_ui_in       = '0;
      bus.cpu_programming = 1'b0;
      busy                = 1'b0;
      done                = 1'b0;

      case (state)
         ST_IDLE, ST_COMPLETE: begin
            done = (state == ST_COMPLETE);
            if (start) begin
               state_nxt  = ST_LOAD;
               fifo_flush = 1'b1;
               in_cnt_nxt = '0;
               sent_nxt   = '0;
               eu_nxt     = 1'b0;
               ee_nxt     = 1'b0;
            end
         end

         ST_LOAD: begin
            busy                = 1'b1;
            bus.cpu_programming = 1'b1;
            fifo_pop            = bus.cpu_ready && !fifo_empty;
            bus.host_ready      = (!fifo_full || fifo_pop) && (in_cnt < PROG_CNT);
            fifo_push           = bus.host_valid && bus.host_ready;
            if (!fifo_empty) bus.cpu_ui_in = fifo_head;
            if (bus.cpu_ready && fifo_empty) eu_nxt = 1'b1;
            if (fifo_push) in_cnt_nxt = in_cnt + CW'(1);
            if (fifo_pop)  sent_nxt   = bytes_sent + CW'(1);
            // Early done is judged on the count before this cycle's pop.
            if (bus.cpu_done_load && (bytes_sent < PROG_CNT)) begin
               ee_nxt    = 1'b1;
               state_nxt = ST_COMPLETE;
            end else if (fifo_pop && (bytes_sent == LAST_CNT)) begin
               state_nxt = ST_WAIT_DONE;
            end
         end

         ST_WAIT_DONE: begin
            busy                = 1'b1;
            bus.cpu_programming = 1'b1;
            if (bus.cpu_done_load) state_nxt = ST_COMPLETE;
         end

         default: state_nxt = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_program_loader.sv
// Randomised and directed bench for program_loader against a queue-based reference model.
module tb_program_loader;
   import cpu_pkg::*;

   localparam int DEPTH = 4;
   localparam int PROG  = 16;
   localparam int CW    = $clog2(PROG) + 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          busy, done, err_underrun, err_early;
   logic [CW-1:0] bytes_sent;

   program_loader_if bus();

   program_loader #(
      .FIFO_DEPTH (DEPTH),
      .PROG_BYTES (PROG)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .bus          (bus),
      .busy         (busy),
      .done         (done),
      .err_underrun (err_underrun),
      .err_early    (err_early),
      .bytes_sent   (bytes_sent)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: phase 0 idle, 1 loading, 2 waiting for done_load, 3 complete.
   int         m_phase;
   logic [7:0] m_q[$];
   int         m_in;
   int         m_sent;
   bit         m_eu;
   bit         m_ee;
   int         hidx;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_phase = 0;
         m_q.delete();
         m_in    = 0;
         m_sent  = 0;
         m_eu    = 0;
         m_ee    = 0;
      end else begin
         case (m_phase)
            0, 3: begin
               if (start) begin
                  m_phase = 1;
                  m_q.delete();
                  m_in   = 0;
                  m_sent = 0;
                  m_eu   = 0;
                  m_ee   = 0;
               end
            end
            1: begin
               bit pop, hr, push, early;
               pop   = bus.cpu_ready && (m_q.size() > 0);
               hr    = (m_in < PROG) && ((m_q.size() < DEPTH) || pop);
               push  = bus.host_valid && hr;
               early = bus.cpu_done_load && (m_sent < PROG);
               if (bus.cpu_ready && m_q.size() == 0) m_eu = 1;
               if (pop) begin
                  void'(m_q.pop_front());
                  m_sent++;
               end
               if (push) begin
                  m_q.push_back(bus.host_data);
                  m_in++;
               end
               if (early) begin
                  m_ee    = 1;
                  m_phase = 3;
               end else if (m_sent == PROG) begin
                  m_phase = 2;
               end
            end
            2: if (bus.cpu_done_load) m_phase = 3;
            default: m_phase = 0;
         endcase
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         bit have;
         have = (m_phase == 1) && (m_q.size() > 0);
         chk("host_ready", bus.host_ready,
             (m_phase == 1) && (m_in < PROG) &&
             ((m_q.size() < DEPTH) || (bus.cpu_ready && m_q.size() > 0)));
         chk("cpu_ui_in", bus.cpu_ui_in, have ? m_q[0] : 8'h00);
         chk("cpu_programming", bus.cpu_programming, (m_phase == 1) || (m_phase == 2));
         chk("busy", busy, (m_phase == 1) || (m_phase == 2));
         chk("done", done, m_phase == 3);
         chk("err_underrun", err_underrun, m_eu);
         chk("err_early", err_early, m_ee);
         chk("bytes_sent", bytes_sent, m_sent);
      end
   end

   task automatic do_start();
      start = 1'b1;
      hidx  = 0;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // done_dly < 0 stops once n_pop bytes are delivered without raising done_load.
   task automatic run_load(input int n_host, input int n_pop, input int period,
                           input int done_dly, input bit rnd, input bit seq_chk,
                           output int accepted);
      int cyc, wait_cnt, k;
      bit fin, acc, fired;
      cyc = 0; wait_cnt = 0; k = 0; fin = 0; accepted = 0;
      while (!fin && cyc < 1000) begin
         bus.host_valid = (hidx < n_host) && (!rnd || $urandom_range(0, 1) == 1);
         bus.host_data  = rnd ? 8'($urandom) : 8'(hidx);
         bus.cpu_ready  = (m_phase == 1) && (m_sent < n_pop) &&
                          (rnd ? ($urandom_range(0, 2) == 0) : (cyc % period == period - 1));
         start = rnd && (m_phase == 1 || m_phase == 2) && ($urandom_range(0, 15) == 0);
         fired = 0;
         if (done_dly >= 0 && (m_sent >= n_pop || m_phase != 1)) begin
            fired = (wait_cnt == done_dly);
            wait_cnt++;
         end
         bus.cpu_done_load = fired;
         #1;
         acc = bus.host_valid && bus.host_ready;
         if (seq_chk && bus.cpu_ready) begin
            chk("seq_byte", bus.cpu_ui_in, k);
            k++;
         end
         @(posedge clk);
         #1;
         if (acc) begin
            hidx++;
            accepted++;
         end
         cyc++;
         if (fired || (done_dly < 0 && m_sent >= n_pop)) fin = 1;
      end
      bus.host_valid    = 1'b0;
      bus.cpu_ready     = 1'b0;
      bus.cpu_done_load = 1'b0;
      start             = 1'b0;
      chk("load_finished", fin, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: actual timeout required finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int acc;
      bit a;
      int np;
      bus.host_valid    = 1'b0;
      bus.host_data     = 8'h00;
      bus.cpu_ready     = 1'b0;
      bus.cpu_done_load = 1'b0;
      hidx = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_prog", bus.cpu_programming, 0);
      chk("rst_ui", bus.cpu_ui_in, 0);
      chk("rst_host_ready", bus.host_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_sent", bytes_sent, 0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      bus.host_valid = 1'b1;
      #1;
      chk("idle_host_ready", bus.host_ready, 0);
      bus.host_valid = 1'b0;

      // Nominal load: strobe every 3rd cycle, done_load two cycles after the last strobe.
      do_start();
      chk("start_prog", bus.cpu_programming, 1);
      run_load(16, 16, 3, 1, 0, 1, acc);
      chk("nom_done", done, 1);
      chk("nom_sent", bytes_sent, 16);
      chk("nom_accepted", acc, 16);
      chk("nom_prog", bus.cpu_programming, 0);
      chk("nom_errs", {err_underrun, err_early}, 0);

      // Backpressure: CPU silent for 10 cycles.
      do_start();
      repeat (10) begin
         bus.host_valid = 1'b1;
         bus.host_data  = 8'(hidx);
         #1;
         a = bus.host_valid && bus.host_ready;
         @(posedge clk);
         #1;
         if (a) hidx++;
      end
      chk("bp_accepted", hidx, 4);
      chk("bp_ready_low", bus.host_ready, 0);
      bus.cpu_ready = 1'b1;
      bus.host_data = 8'(hidx);
      #1;
      chk("bp_head", bus.cpu_ui_in, 8'h00);
      chk("bp_ready_again", bus.host_ready, 1);
      a = bus.host_valid && bus.host_ready;
      @(posedge clk);
      #1;
      if (a) hidx++;
      bus.cpu_ready  = 1'b0;
      bus.host_valid = 1'b0;
      run_load(16, 16, 2, 0, 0, 0, acc);
      chk("bp_sent", bytes_sent, 16);
      chk("bp_done", done, 1);

      // Underrun: strobes before any host byte.
      do_start();
      bus.cpu_ready = 1'b1;
      #1;
      chk("un_ui", bus.cpu_ui_in, 8'h00);
      repeat (2) @(posedge clk);
      #1;
      bus.cpu_ready = 1'b0;
      chk("un_flag", err_underrun, 1);
      chk("un_sent", bytes_sent, 0);
      run_load(16, 16, 2, 0, 0, 0, acc);
      chk("un_done", done, 1);
      chk("un_sent_full", bytes_sent, 16);
      chk("un_flag_hold", err_underrun, 1);

      // Early done after 5 bytes.
      do_start();
      run_load(16, 5, 2, 0, 0, 0, acc);
      chk("early_flag", err_early, 1);
      chk("early_done", done, 1);
      chk("early_prog", bus.cpu_programming, 0);
      chk("early_sent", bytes_sent, 5);

      // Reload from COMPLETE with a host offering 20 bytes.
      do_start();
      chk("rl_ee_clear", err_early, 0);
      chk("rl_eu_clear", err_underrun, 0);
      chk("rl_sent_clear", bytes_sent, 0);
      run_load(20, 16, 2, 0, 0, 0, acc);
      chk("rl_accepted", acc, 16);
      chk("rl_done", done, 1);

      // Reset in the middle of a load.
      do_start();
      run_load(16, 7, 2, -1, 0, 0, acc);
      chk("rs_before", bytes_sent, 7);
      rst = 1'b1;
      #1;
      chk("rs_prog", bus.cpu_programming, 0);
      chk("rs_busy", busy, 0);
      chk("rs_sent", bytes_sent, 0);
      chk("rs_ui", bus.cpu_ui_in, 8'h00);
      @(posedge clk);
      #1;
      rst = 1'b0;
      do_start();
      run_load(16, 16, 3, 1, 0, 1, acc);
      chk("rs_done", done, 1);
      chk("rs_sent_full", bytes_sent, 16);
      chk("rs_errs", {err_underrun, err_early}, 0);

      // Randomised loads, some ending early.
      repeat (10) begin
         do_start();
         np = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 15) : 16;
         run_load(16 + $urandom_range(0, 4), np, 1, $urandom_range(0, 3), 1, 0, acc);
         chk("rnd_done", done, 1);
      end

      repeat (2) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
